// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared types for the pipelined operand/writeback controller: source and writeback
// selector encodings.
package pipe_ctrl_unit_pkg;

    localparam int unsigned SelWidth = 2;

    typedef enum logic [SelWidth-1:0] {
        OpAReg = 2'd0,
        OpAPc  = 2'd1,
        OpAImm = 2'd2
    } alu_op_a_sel_e;

    typedef enum logic [SelWidth-1:0] {
        OpBReg = 2'd0,
        OpBImm = 2'd1
    } alu_op_b_sel_e;

    typedef enum logic [SelWidth-1:0] {
        WpAlu     = 2'd0,
        WpPcPlus4 = 2'd1,
        WpLsu     = 2'd2
    } rf_wp_sel_e;

    function automatic logic sel_is_lsu(input logic [SelWidth-1:0] sel);
        return sel == WpLsu;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Decode/datapath bundle between the decoder, register file, ALU, LSU and the pipeline
// controller; slave is the controller side.
interface pipe_ctrl_unit_if
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned RA_WIDTH   = 5
);
    logic                  id_valid_i;
    logic                  id_ready_o;
    logic                  flush_i;
    logic [SelWidth-1:0]   alu_op_a_sel_i;
    logic [SelWidth-1:0]   alu_op_b_sel_i;
    logic [SelWidth-1:0]   rf_wp_sel_i;
    logic                  rs1_valid_i;
    logic                  rs2_valid_i;
    logic                  imm_valid_i;
    logic [RA_WIDTH-1:0]   rs1_addr_i;
    logic [RA_WIDTH-1:0]   rs2_addr_i;
    logic [RA_WIDTH-1:0]   rd_addr_i;
    logic                  rd_we_i;
    logic [DATA_WIDTH-1:0] rf_rp_a_i;
    logic [DATA_WIDTH-1:0] rf_rp_b_i;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [ADDR_WIDTH-1:0] pc_i;
    logic [ADDR_WIDTH-1:0] pc_plus4_i;
    logic [DATA_WIDTH-1:0] alu_op_a_o;
    logic [DATA_WIDTH-1:0] alu_op_b_o;
    logic [DATA_WIDTH-1:0] alu_result_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  rf_we_o;
    logic [RA_WIDTH-1:0]   rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wp_o;

    modport master (
        output id_valid_i, flush_i, alu_op_a_sel_i, alu_op_b_sel_i, rf_wp_sel_i,
               rs1_valid_i, rs2_valid_i, imm_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
               rd_we_i, rf_rp_a_i, rf_rp_b_i, imm_i, pc_i, pc_plus4_i, alu_result_i,
               mem_rdata_i,
        input  id_ready_o, alu_op_a_o, alu_op_b_o, rf_we_o, rf_waddr_o, rf_wp_o
    );

    modport slave (
        input  id_valid_i, flush_i, alu_op_a_sel_i, alu_op_b_sel_i, rf_wp_sel_i,
               rs1_valid_i, rs2_valid_i, imm_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
               rd_we_i, rf_rp_a_i, rf_rp_b_i, imm_i, pc_i, pc_plus4_i, alu_result_i,
               mem_rdata_i,
        output id_ready_o, alu_op_a_o, alu_op_b_o, rf_we_o, rf_waddr_o, rf_wp_o
    );

endinterface

// File: rtl/pipe_ctrl_unit_operand_fwd_mux.sv
// Per-source forwarding mux: picks the newest in-flight value for one register source
// and flags a hazard when that value cannot be delivered this cycle.
module operand_fwd_mux #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RA_WIDTH   = 5,
    parameter bit          FWD_EN     = 1'b1
) (
    input  logic                  used_i,
    input  logic [RA_WIDTH-1:0]   rs_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    input  logic                  m_valid_i,
    input  logic                  m_we_i,
    input  logic                  m_lsu_i,
    input  logic [RA_WIDTH-1:0]   m_rd_i,
    input  logic [DATA_WIDTH-1:0] m_data_i,
    input  logic                  w_valid_i,
    input  logic                  w_we_i,
    input  logic [RA_WIDTH-1:0]   w_rd_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  hazard_o
);
    logic rs_zero;
    logic m_hit;
    logic w_hit;

    always_comb begin
        rs_zero  = (rs_i == '0);
        m_hit    = m_valid_i & m_we_i & (m_rd_i == rs_i) & ~rs_zero;
        w_hit    = w_valid_i & w_we_i & (w_rd_i == rs_i) & ~rs_zero;
        data_o   = rf_data_i;
        hazard_o = 1'b0;
        if (rs_zero) begin
            data_o = '0;
        end else if (FWD_EN) begin
            // A load in M has no data yet; fall through and let the hazard stall EX.
            if (m_hit && !m_lsu_i) begin
                data_o = m_data_i;
            end else if (w_hit) begin
                data_o = w_data_i;
            end
        end
        if (FWD_EN) begin
            hazard_o = used_i & m_hit & m_lsu_i;
        end else begin
            hazard_o = used_i & (m_hit | w_hit);
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// EX-stage operand selection with M/W forwarding, load-use stall, and the registered
// EX->M->W writeback path driving the register-file write port.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned RA_WIDTH   = 5,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipe_ctrl_unit_if.slave      bus,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);
    typedef struct packed {
        logic                  valid;
        logic [RA_WIDTH-1:0]   rd;
        logic                  we;
        logic [SelWidth-1:0]   sel;
        logic [DATA_WIDTH-1:0] alu;
        logic [ADDR_WIDTH-1:0] pc4;
    } pipe_stage_t;

    pipe_stage_t           m_q, m_d, w_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] m_val, wb_val, fwd_a, fwd_b, op_a, op_b;
    logic                  used_a, used_b, haz_a, haz_b, hazard, accept;

    assign m_val  = (m_q.sel == WpPcPlus4) ? DATA_WIDTH'(m_q.pc4) : m_q.alu;
    assign used_a = bus.id_valid_i & bus.rs1_valid_i & (bus.alu_op_a_sel_i == OpAReg);
    assign used_b = bus.id_valid_i & bus.rs2_valid_i & (bus.alu_op_b_sel_i == OpBReg);

    always_comb begin
        case (w_q.sel)
            WpPcPlus4: wb_val = DATA_WIDTH'(w_q.pc4);
            WpLsu:     wb_val = bus.mem_rdata_i;
            default:   wb_val = w_q.alu;
        endcase
    end

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .RA_WIDTH(RA_WIDTH), .FWD_EN(FWD_EN)) u_fwd_a (
        .used_i(used_a), .rs_i(bus.rs1_addr_i), .rf_data_i(bus.rf_rp_a_i),
        .m_valid_i(m_q.valid), .m_we_i(m_q.we), .m_lsu_i(sel_is_lsu(m_q.sel)),
        .m_rd_i(m_q.rd), .m_data_i(m_val),
        .w_valid_i(w_q.valid), .w_we_i(w_q.we), .w_rd_i(w_q.rd), .w_data_i(wb_val),
        .data_o(fwd_a), .hazard_o(haz_a)
    );

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .RA_WIDTH(RA_WIDTH), .FWD_EN(FWD_EN)) u_fwd_b (
        .used_i(used_b), .rs_i(bus.rs2_addr_i), .rf_data_i(bus.rf_rp_b_i),
        .m_valid_i(m_q.valid), .m_we_i(m_q.we), .m_lsu_i(sel_is_lsu(m_q.sel)),
        .m_rd_i(m_q.rd), .m_data_i(m_val),
        .w_valid_i(w_q.valid), .w_we_i(w_q.we), .w_rd_i(w_q.rd), .w_data_i(wb_val),
        .data_o(fwd_b), .hazard_o(haz_b)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        if (bus.id_valid_i) begin
            case (bus.alu_op_a_sel_i)
                OpAReg:  if (bus.rs1_valid_i) op_a = fwd_a;
                OpAPc:   op_a = DATA_WIDTH'(bus.pc_i);
                OpAImm:  if (bus.imm_valid_i) op_a = bus.imm_i;
                default: op_a = '0;
            endcase
            case (bus.alu_op_b_sel_i)
                OpBReg:  if (bus.rs2_valid_i) op_b = fwd_b;
                OpBImm:  if (bus.imm_valid_i) op_b = bus.imm_i;
                default: op_b = '0;
            endcase
        end
    end

    assign hazard = haz_a | haz_b;
    // Flush beats stall: a killed instruction neither enters M nor counts as stalled.
    assign accept = bus.id_valid_i & ~hazard & ~bus.flush_i;

    always_comb begin
        m_d = '0;
        if (accept) begin
            m_d.valid = 1'b1;
            m_d.rd    = bus.rd_addr_i;
            m_d.we    = bus.rd_we_i;
            m_d.sel   = bus.rf_wp_sel_i;
            m_d.alu   = bus.alu_result_i;
            m_d.pc4   = bus.pc_plus4_i;
        end
        cnt_d = cnt_q;
        if (bus.id_valid_i && hazard && !bus.flush_i && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            m_q   <= m_d;
            w_q   <= m_q;
            cnt_q <= cnt_d;
        end
    end

    assign bus.id_ready_o = ~hazard;
    assign bus.alu_op_a_o = op_a;
    assign bus.alu_op_b_o = op_b;
    assign bus.rf_we_o    = w_q.valid & w_q.we & (w_q.rd != '0);
    assign bus.rf_waddr_o = w_q.rd;
    assign bus.rf_wp_o    = wb_val;
    assign stall_cnt_o    = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: a program-order register model predicts operands, stalls and
// writebacks for a forwarding instance; a non-forwarding instance gets a directed case.
module tb_pipe_ctrl_unit;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RA_WIDTH(RW)) b1 ();
    pipe_ctrl_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RA_WIDTH(RW)) b0 ();
    logic [CW-1:0] cnt1, cnt0;

    pipe_ctrl_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RA_WIDTH(RW), .FWD_EN(1'b1),
                     .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .bus(b1.slave), .stall_cnt_o(cnt1)
    );
    pipe_ctrl_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RA_WIDTH(RW), .FWD_EN(1'b0),
                     .CNT_WIDTH(CW)) dut_nf (
        .clk_i(clk), .rst_i(rst), .bus(b0.slave), .stall_cnt_o(cnt0)
    );

    // One accepted instruction, with the value it will eventually write.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        we;
        logic        load;
        logic [31:0] val;
    } slot_t;

    slot_t       s1, s2;           // accepted one and two cycles ago
    logic [31:0] arch [32];        // program-order register values
    logic [31:0] phys [32];        // register-file contents as actually written
    logic [31:0] ld_data;
    logic [CW-1:0] e_cnt;
    logic        e_ready, e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_a, e_b, e_wp;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) arch[i] = phys[i];
        s1.valid = 1'b0;
        s2.valid = 1'b0;
        e_cnt = '0;
    endtask

    task automatic set_instr(input logic v, input logic fl, input logic [1:0] as,
                             input logic [1:0] bs, input logic [1:0] wp, input logic [4:0] r1,
                             input logic [4:0] r2, input logic [4:0] rd, input logic we,
                             input logic [31:0] imm, input logic [31:0] alu);
        b1.id_valid_i = v;   b1.flush_i = fl;
        b1.alu_op_a_sel_i = as; b1.alu_op_b_sel_i = bs; b1.rf_wp_sel_i = wp;
        b1.rs1_valid_i = 1'b1; b1.rs2_valid_i = 1'b1; b1.imm_valid_i = 1'b1;
        b1.rs1_addr_i = r1; b1.rs2_addr_i = r2; b1.rd_addr_i = rd; b1.rd_we_i = we;
        b1.imm_i = imm; b1.alu_result_i = alu;
        b1.pc_i = 32'h0000_1000; b1.pc_plus4_i = 32'h0000_1004;
    endtask

    task automatic idle();
        set_instr(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    endtask

    // Drive register-file/load data from the model and form this cycle's expectations.
    task automatic prep();
        logic hz_a, hz_b;
        b1.rf_rp_a_i = phys[b1.rs1_addr_i];
        b1.rf_rp_b_i = phys[b1.rs2_addr_i];
        b1.mem_rdata_i = (s2.valid && s2.load) ? s2.val : $urandom;
        hz_a = b1.id_valid_i && b1.alu_op_a_sel_i == 2'd0 && b1.rs1_valid_i &&
               b1.rs1_addr_i != 0 && s1.valid && s1.we && s1.load && s1.rd == b1.rs1_addr_i;
        hz_b = b1.id_valid_i && b1.alu_op_b_sel_i == 2'd0 && b1.rs2_valid_i &&
               b1.rs2_addr_i != 0 && s1.valid && s1.we && s1.load && s1.rd == b1.rs2_addr_i;
        e_ready = !(hz_a || hz_b);
        e_a = 32'd0;
        e_b = 32'd0;
        if (b1.id_valid_i) begin
            case (b1.alu_op_a_sel_i)
                2'd0: if (b1.rs1_valid_i && b1.rs1_addr_i != 0) e_a = arch[b1.rs1_addr_i];
                2'd1: e_a = b1.pc_i;
                2'd2: if (b1.imm_valid_i) e_a = b1.imm_i;
                default: e_a = 32'd0;
            endcase
            case (b1.alu_op_b_sel_i)
                2'd0: if (b1.rs2_valid_i && b1.rs2_addr_i != 0) e_b = arch[b1.rs2_addr_i];
                2'd1: if (b1.imm_valid_i) e_b = b1.imm_i;
                default: e_b = 32'd0;
            endcase
        end
        e_we = s2.valid && s2.we && s2.rd != 0;
        e_waddr = s2.rd;
        e_wp = s2.val;
        #1;
    endtask

    // Apply the effect of the coming clock edge to the model.
    task automatic commit();
        slot_t n;
        if (e_we) phys[s2.rd] = s2.val;
        n.valid = b1.id_valid_i && e_ready && !b1.flush_i;
        n.rd = b1.rd_addr_i;
        n.we = b1.rd_we_i;
        n.load = (b1.rf_wp_sel_i == 2'd2);
        n.val = (b1.rf_wp_sel_i == 2'd1) ? b1.pc_plus4_i :
                (b1.rf_wp_sel_i == 2'd2) ? ld_data : b1.alu_result_i;
        if (n.valid && n.we && n.rd != 0) arch[n.rd] = n.val;
        if (b1.id_valid_i && !e_ready && !b1.flush_i && e_cnt != '1) e_cnt = e_cnt + 1'b1;
        s2 = s1;
        s1 = n;
    endtask

    task automatic test_reset();
        @(negedge clk); idle(); prep();
        n_chk++; if (b1.id_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0b exp=1", b1.id_ready_o); end
        n_chk++; if (b1.rf_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we got=%0b exp=0", b1.rf_we_o); end
        n_chk++; if (b1.rf_waddr_o !== 5'd0 || b1.rf_wp_o !== 32'd0) begin n_err++; $display("FAIL reset_wport got=%0d/%h exp=0/0", b1.rf_waddr_o, b1.rf_wp_o); end
        n_chk++; if (cnt1 !== 16'd0 || cnt0 !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt1, cnt0); end
        n_chk++; if (b1.alu_op_a_o !== 32'd0 || b1.alu_op_b_o !== 32'd0) begin n_err++; $display("FAIL reset_ops got=%h/%h exp=0/0", b1.alu_op_a_o, b1.alu_op_b_o); end
        commit();
    endtask

    task automatic test_no_fwd();
        @(negedge clk);  // ADDI x1, x0, 5
        b0.id_valid_i = 1; b0.alu_op_a_sel_i = 2'd0; b0.rs1_addr_i = 5'd0; b0.rs1_valid_i = 1;
        b0.alu_op_b_sel_i = 2'd1; b0.imm_i = 32'd5; b0.imm_valid_i = 1; b0.rs2_valid_i = 0;
        b0.rd_addr_i = 5'd1; b0.rd_we_i = 1; b0.rf_wp_sel_i = 2'd0; b0.alu_result_i = 32'd5;
        b0.rf_rp_a_i = 32'd0; #1;
        n_chk++; if (b0.id_ready_o !== 1'b1) begin n_err++; $display("FAIL nofwd_addi_ready got=%0b exp=1", b0.id_ready_o); end
        @(negedge clk);  // ADD x2, x1, x0
        b0.rs1_addr_i = 5'd1; b0.alu_op_b_sel_i = 2'd0; b0.rs2_addr_i = 5'd0; b0.rs2_valid_i = 1;
        b0.rd_addr_i = 5'd2; b0.alu_result_i = 32'd0; #1;
        n_chk++; if (b0.id_ready_o !== 1'b0) begin n_err++; $display("FAIL nofwd_stall_m got=%0b exp=0", b0.id_ready_o); end
        @(negedge clk); #1;
        n_chk++; if (b0.id_ready_o !== 1'b0) begin n_err++; $display("FAIL nofwd_stall_w got=%0b exp=0", b0.id_ready_o); end
        n_chk++; if (b0.rf_we_o !== 1'b1 || b0.rf_waddr_o !== 5'd1 || b0.rf_wp_o !== 32'd5) begin n_err++; $display("FAIL nofwd_wb got=%0b/%0d/%h exp=1/1/5", b0.rf_we_o, b0.rf_waddr_o, b0.rf_wp_o); end
        @(negedge clk); b0.rf_rp_a_i = 32'd5; #1;
        n_chk++; if (b0.id_ready_o !== 1'b1) begin n_err++; $display("FAIL nofwd_release got=%0b exp=1", b0.id_ready_o); end
        n_chk++; if (b0.alu_op_a_o !== 32'd5) begin n_err++; $display("FAIL nofwd_op_a got=%h exp=5", b0.alu_op_a_o); end
        n_chk++; if (cnt0 !== 16'd2) begin n_err++; $display("FAIL nofwd_cnt got=%0d exp=2", cnt0); end
        @(negedge clk); b0.id_valid_i = 0;
    endtask

    task automatic test_fwd_m();
        @(negedge clk); set_instr(1, 0, 2'd0, 2'd1, 2'd0, 5'd0, 5'd0, 5'd1, 1, 32'd5, 32'd5); prep();
        n_chk++; if (b1.id_ready_o !== 1'b1) begin n_err++; $display("FAIL fwdm_addi_ready got=%0b exp=1", b1.id_ready_o); end
        commit();
        @(negedge clk); set_instr(1, 0, 2'd0, 2'd0, 2'd0, 5'd1, 5'd1, 5'd2, 1, 32'd0, 32'd10); prep();
        n_chk++; if (b1.id_ready_o !== 1'b1) begin n_err++; $display("FAIL fwdm_add_ready got=%0b exp=1", b1.id_ready_o); end
        n_chk++; if (b1.alu_op_a_o !== 32'd5 || b1.alu_op_b_o !== 32'd5) begin n_err++; $display("FAIL fwdm_ops got=%h/%h exp=5/5", b1.alu_op_a_o, b1.alu_op_b_o); end
        commit();
        @(negedge clk); idle(); prep();
        n_chk++; if (b1.rf_we_o !== 1'b1 || b1.rf_waddr_o !== 5'd1 || b1.rf_wp_o !== 32'd5) begin n_err++; $display("FAIL fwdm_wb got=%0b/%0d/%h exp=1/1/5", b1.rf_we_o, b1.rf_waddr_o, b1.rf_wp_o); end
        commit();
    endtask

    task automatic test_load_use();
        logic [CW-1:0] c0;
        ld_data = 32'hCAFE;
        @(negedge clk); set_instr(1, 0, 2'd0, 2'd1, 2'd2, 5'd0, 5'd0, 5'd3, 1, 32'd4, 32'd4); prep();
        c0 = e_cnt;
        commit();
        @(negedge clk); set_instr(1, 0, 2'd0, 2'd0, 2'd0, 5'd3, 5'd0, 5'd4, 1, 32'd0, 32'hCAFE); prep();
        n_chk++; if (b1.id_ready_o !== 1'b0) begin n_err++; $display("FAIL lduse_stall got=%0b exp=0", b1.id_ready_o); end
        commit();
        @(negedge clk); prep();
        n_chk++; if (b1.id_ready_o !== 1'b1) begin n_err++; $display("FAIL lduse_release got=%0b exp=1", b1.id_ready_o); end
        n_chk++; if (b1.alu_op_a_o !== 32'hCAFE || b1.alu_op_b_o !== 32'd0) begin n_err++; $display("FAIL lduse_ops got=%h/%h exp=cafe/0", b1.alu_op_a_o, b1.alu_op_b_o); end
        n_chk++; if (cnt1 !== c0 + 16'd1) begin n_err++; $display("FAIL lduse_cnt got=%0d exp=%0d", cnt1, c0 + 16'd1); end
        commit();
        @(negedge clk); idle(); prep(); commit();
    endtask

    task automatic test_x0();
        @(negedge clk); set_instr(1, 0, 2'd2, 2'd1, 2'd0, 5'd0, 5'd0, 5'd0, 1, 32'h1234, 32'h1234); prep(); commit();
        @(negedge clk); set_instr(1, 0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd9, 0, 32'd0, 32'd0); prep();
        b1.rf_rp_a_i = 32'hDEAD_BEEF; b1.rf_rp_b_i = 32'h0BAD_F00D; #1;
        n_chk++; if (b1.alu_op_a_o !== 32'd0 || b1.alu_op_b_o !== 32'd0) begin n_err++; $display("FAIL x0_read got=%h/%h exp=0/0", b1.alu_op_a_o, b1.alu_op_b_o); end
        commit();
        @(negedge clk); idle(); prep();
        n_chk++; if (b1.rf_we_o !== 1'b0) begin n_err++; $display("FAIL x0_write got=%0b exp=0", b1.rf_we_o); end
        commit();
    endtask

    task automatic test_flush_stall();
        logic [CW-1:0] c0;
        ld_data = 32'hCAFE;
        @(negedge clk); set_instr(1, 0, 2'd0, 2'd1, 2'd2, 5'd0, 5'd0, 5'd5, 1, 32'd8, 32'd8); prep();
        c0 = e_cnt;
        commit();
        @(negedge clk); set_instr(1, 1, 2'd0, 2'd1, 2'd0, 5'd5, 5'd0, 5'd6, 1, 32'd1, 32'h66); prep();
        n_chk++; if (b1.id_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%0b exp=0", b1.id_ready_o); end
        commit();
        @(negedge clk); idle(); prep();
        n_chk++; if (cnt1 !== c0) begin n_err++; $display("FAIL flush_cnt got=%0d exp=%0d", cnt1, c0); end
        n_chk++; if (b1.rf_we_o !== 1'b1 || b1.rf_waddr_o !== 5'd5 || b1.rf_wp_o !== 32'hCAFE) begin n_err++; $display("FAIL flush_ld_wb got=%0b/%0d/%h exp=1/5/cafe", b1.rf_we_o, b1.rf_waddr_o, b1.rf_wp_o); end
        commit();
        @(negedge clk); idle(); prep();
        n_chk++; if (b1.rf_we_o !== 1'b0) begin n_err++; $display("FAIL flush_no_wb got=%0b exp=0", b1.rf_we_o); end
        commit();
    endtask

    task automatic test_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            b1.id_valid_i = ($urandom_range(4) != 0);
            b1.flush_i = ($urandom_range(9) == 0);
            b1.alu_op_a_sel_i = 2'($urandom_range(3));
            b1.alu_op_b_sel_i = 2'($urandom_range(3));
            b1.rf_wp_sel_i = 2'($urandom_range(3));
            b1.rs1_valid_i = ($urandom_range(5) != 0);
            b1.rs2_valid_i = ($urandom_range(5) != 0);
            b1.imm_valid_i = ($urandom_range(5) != 0);
            b1.rs1_addr_i = 5'($urandom_range(7));
            b1.rs2_addr_i = 5'($urandom_range(7));
            b1.rd_addr_i = 5'($urandom_range(7));
            b1.rd_we_i = ($urandom_range(3) != 0);
            b1.imm_i = $urandom; b1.pc_i = $urandom; b1.pc_plus4_i = $urandom;
            b1.alu_result_i = $urandom;
            ld_data = $urandom;
            prep();
            n_chk++; if (b1.id_ready_o !== e_ready) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", i, b1.id_ready_o, e_ready); end
            n_chk++; if (cnt1 !== e_cnt) begin n_err++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, cnt1, e_cnt); end
            n_chk++; if (b1.rf_we_o !== e_we) begin n_err++; $display("FAIL rnd_we cyc=%0d got=%0b exp=%0b", i, b1.rf_we_o, e_we); end
            if (e_ready) begin
                n_chk++; if (b1.alu_op_a_o !== e_a || b1.alu_op_b_o !== e_b) begin n_err++; $display("FAIL rnd_ops cyc=%0d got=%h/%h exp=%h/%h", i, b1.alu_op_a_o, b1.alu_op_b_o, e_a, e_b); end
            end
            if (e_we) begin
                n_chk++; if (b1.rf_waddr_o !== e_waddr || b1.rf_wp_o !== e_wp) begin n_err++; $display("FAIL rnd_wport cyc=%0d got=%0d/%h exp=%0d/%h", i, b1.rf_waddr_o, b1.rf_wp_o, e_waddr, e_wp); end
            end
            commit();
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk); set_instr(1, 0, 2'd2, 2'd1, 2'd0, 5'd0, 5'd0, 5'd7, 1, 32'd0, 32'h77); prep(); commit();
        @(negedge clk); set_instr(1, 0, 2'd2, 2'd1, 2'd0, 5'd0, 5'd0, 5'd8, 1, 32'd0, 32'h88); prep(); commit();
        @(negedge clk); idle(); prep();
        n_chk++; if (b1.rf_we_o !== 1'b1) begin n_err++; $display("FAIL mid_pre_we got=%0b exp=1", b1.rf_we_o); end
        rst = 1'b1; #1;
        n_chk++; if (b1.rf_we_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_we got=%0b exp=0", b1.rf_we_o); end
        n_chk++; if (cnt1 !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt got=%0d exp=0", cnt1); end
        n_chk++; if (b1.rf_waddr_o !== 5'd0 || b1.rf_wp_o !== 32'd0) begin n_err++; $display("FAIL mid_rst_wport got=%0d/%h exp=0/0", b1.rf_waddr_o, b1.rf_wp_o); end
        model_reset();
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); prep();
            n_chk++; if (b1.rf_we_o !== 1'b0) begin n_err++; $display("FAIL mid_post_we cyc=%0d got=%0b exp=0", i, b1.rf_we_o); end
            commit();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin arch[i] = 32'd0; phys[i] = 32'd0; end
        ld_data = 32'd0;
        idle();
        b1.rf_rp_a_i = '0; b1.rf_rp_b_i = '0; b1.mem_rdata_i = '0;
        b0.id_valid_i = 0; b0.flush_i = 0; b0.alu_op_a_sel_i = '0; b0.alu_op_b_sel_i = '0;
        b0.rf_wp_sel_i = '0; b0.rs1_valid_i = 0; b0.rs2_valid_i = 0; b0.imm_valid_i = 0;
        b0.rs1_addr_i = '0; b0.rs2_addr_i = '0; b0.rd_addr_i = '0; b0.rd_we_i = 0;
        b0.rf_rp_a_i = '0; b0.rf_rp_b_i = '0; b0.imm_i = '0; b0.pc_i = '0; b0.pc_plus4_i = '0;
        b0.alu_result_i = '0; b0.mem_rdata_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_no_fwd();
        test_fwd_m();
        test_load_use();
        test_x0();
        test_flush_stall();
        test_random(400);
        test_reset_midstream();
        test_random(60);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
